// File: rtl/shifter_pkg.sv
// Shared encodings for the parametrised sequential shifter: shift modes,
// FSM states and the per-bit cell source select.
package shifter_pkg;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Source of a bit cell's next value; LEFT is the higher-index neighbour.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LOAD  = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_RIGHT = 2'b11
  } cell_sel_e;

endpackage

// File: rtl/shift_cell.sv
// One bit of the shift register: picks hold / parallel load / left or right
// neighbour and registers it with a synchronous active-high reset.
module shift_cell
  import shifter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  cell_sel_e sel,
  input  logic      load_val,
  input  logic      left_in,
  input  logic      right_in,
  output logic      q
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    unique case (sel)
      SEL_HOLD:  q_nxt = q;
      SEL_LOAD:  q_nxt = load_val;
      SEL_LEFT:  q_nxt = left_in;
      SEL_RIGHT: q_nxt = right_in;
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= q_nxt;
  end

endmodule

// File: rtl/shifter_param_seq.sv
// Multi-mode shift register: parallel load, then a multi-bit shift executed
// one position per clock under a start/busy/done handshake.
module shifter_param_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             serial_out
);

  state_e           state, state_nxt;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_r;
  cell_sel_e        cell_sel;
  logic             fill_msb;
  logic [WIDTH-1:0] left_nb;
  logic [WIDTH-1:0] right_nb;
  logic             start_acc;
  logic             last_step;

  // Load wins over start in IDLE; a start that loses is dropped.
  assign start_acc = (state == ST_IDLE) && start && !load;
  assign last_step = (state == ST_SHIFT) && (cnt == AMT_W'(1));
  assign busy      = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_acc && (amount != '0)) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_step)                   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cell_sel = SEL_HOLD;
    unique case (state)
      ST_IDLE:  if (load) cell_sel = SEL_LOAD;
      ST_SHIFT: cell_sel = (mode_r == MODE_LSL) ? SEL_RIGHT : SEL_LEFT;
      default:  cell_sel = SEL_HOLD;
    endcase
  end

  // Bit entering the MSB on right-going shifts.
  always_comb begin
    fill_msb = 1'b0;
    unique case (mode_r)
      MODE_ASR: fill_msb = q[WIDTH-1];
      MODE_ROR: fill_msb = q[0];
      default:  fill_msb = 1'b0;
    endcase
  end

  assign left_nb  = {fill_msb, q[WIDTH-1:1]};
  assign right_nb = {q[WIDTH-2:0], 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .sel      (cell_sel),
      .load_val (d[i]),
      .left_in  (left_nb[i]),
      .right_in (right_nb[i]),
      .q        (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      mode_r     <= MODE_LSR;
      done       <= 1'b0;
      serial_out <= 1'b0;
    end else begin
      done <= (start_acc && (amount == '0)) || last_step;
      if (start_acc) begin
        cnt    <= amount;
        mode_r <= mode;
      end else if (state == ST_SHIFT) begin
        cnt        <= cnt - AMT_W'(1);
        serial_out <= (mode_r == MODE_LSL) ? q[WIDTH-1] : q[0];
      end
    end
  end

endmodule

// File: tb/tb_shifter_param_seq.sv
// Directed, table-driven bench for shifter_param_seq (WIDTH=8, AMT_W=4).
module tb_shifter_param_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       load;
  logic       start;
  logic [3:0] amount;
  logic [1:0] mode;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       serial_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shifter_param_seq #(.WIDTH(8), .AMT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .load       (load),
    .start      (start),
    .amount     (amount),
    .mode       (mode),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .serial_out (serial_out)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] amt;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val);
    d    = val;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Issue a start and wait for busy to drop; returns cycles busy was seen.
  task automatic do_shift(input logic [1:0] m, input logic [3:0] n, input bit toggle,
                          output int cycles, output bit overlap);
    mode   = m;
    amount = n;
    start  = 1'b1;
    tick();
    start   = 1'b0;
    cycles  = 0;
    overlap = 1'b0;
    while (busy && cycles < 100) begin
      if (done) overlap = 1'b1;
      if (toggle) begin
        load   = ~load;
        start  = 1'b1;
        d      = ~d;
        mode   = mode + 2'd1;
        amount = amount + 4'd3;
      end
      cycles++;
      tick();
    end
    load  = 1'b0;
    start = 1'b0;
  endtask

  int cyc;
  bit ovl;

  initial begin
    vecs[0] = '{2'b01, 4'd3,  8'hB4, 8'hF6, 1'b1};
    vecs[1] = '{2'b00, 4'd3,  8'hB4, 8'h16, 1'b1};
    vecs[2] = '{2'b10, 4'd2,  8'hB4, 8'hD0, 1'b0};
    vecs[3] = '{2'b11, 4'd9,  8'h81, 8'hC0, 1'b1};
    vecs[4] = '{2'b00, 4'd10, 8'hFF, 8'h00, 1'b0};
    vecs[5] = '{2'b01, 4'd12, 8'h80, 8'hFF, 1'b1};
    vecs[6] = '{2'b10, 4'd8,  8'hFF, 8'h00, 1'b1};
    vecs[7] = '{2'b11, 4'd3,  8'h01, 8'h20, 1'b0};

    reset = 1'b1; d = '0; load = 0; start = 0; amount = '0; mode = '0;
    tick(); tick();
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_so", 32'(serial_out), 32'h0);
    reset = 1'b0;

    do_load(8'hB4);
    check("load_q", 32'(q), 32'hB4);
    check("load_busy", 32'(busy), 32'h0);
    check("load_done", 32'(done), 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].d);
      do_shift(vecs[i].mode, vecs[i].amt, 1'b0, cyc, ovl);
      check($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].amt));
      check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("v%0d_so", i), 32'(serial_out), 32'(vecs[i].exp_so));
      check($sformatf("v%0d_done", i), 32'(done), 32'h1);
      check($sformatf("v%0d_overlap", i), 32'(ovl), 32'h0);
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
    end

    // LSL by 2 followed by a zero-length shift.
    do_load(8'hB4);
    do_shift(2'b10, 4'd2, 1'b0, cyc, ovl);
    check("lsl2_q", 32'(q), 32'hD0);
    tick();
    do_shift(2'b10, 4'd0, 1'b0, cyc, ovl);
    check("amt0_busy_cycles", 32'(cyc), 32'h0);
    check("amt0_done", 32'(done), 32'h1);
    check("amt0_q", 32'(q), 32'hD0);
    check("amt0_so", 32'(serial_out), 32'h0);
    tick();
    check("amt0_done_pulse", 32'(done), 32'h0);

    // Inputs wiggling during a ROR 9 must be ignored.
    do_load(8'h81);
    do_shift(2'b11, 4'd9, 1'b1, cyc, ovl);
    check("ror9_toggle_cycles", 32'(cyc), 32'h9);
    check("ror9_toggle_q", 32'(q), 32'hC0);
    check("ror9_toggle_done", 32'(done), 32'h1);
    // Start accepted in the same cycle done is high.
    do_shift(2'b00, 4'd1, 1'b0, cyc, ovl);
    check("start_on_done_cycles", 32'(cyc), 32'h1);
    check("start_on_done_q", 32'(q), 32'h60);

    // Load and start together: load wins, start dropped.
    tick();
    d = 8'h3C; load = 1'b1; start = 1'b1; amount = 4'd3; mode = 2'b00;
    tick();
    load = 1'b0; start = 1'b0;
    check("ld_st_q", 32'(q), 32'h3C);
    check("ld_st_busy", 32'(busy), 32'h0);
    tick();
    check("ld_st_busy2", 32'(busy), 32'h0);
    check("ld_st_done2", 32'(done), 32'h0);
    check("ld_st_q2", 32'(q), 32'h3C);

    // Reset in the middle of a 5-step shift.
    do_load(8'hFF);
    mode = 2'b00; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_busy", 32'(busy), 32'h1);
    tick();
    check("mid_q_step1", 32'(q), 32'h7F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_q", 32'(q), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_so", 32'(serial_out), 32'h0);
    tick();
    check("mid_rst_busy_after", 32'(busy), 32'h0);
    check("mid_rst_done_after", 32'(done), 32'h0);
    // FSM is back in IDLE: a fresh load is accepted.
    do_load(8'hA5);
    check("post_rst_load", 32'(q), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
